// File: rtl/lfi_redundant_counter_if.sv
// Bundles the control inputs and the display and fault outputs of the
// redundant digit counter. Plain clk/reset stay outside the bundle.
//   master: drives compare_sel, clear_fault, inject_a; observes outputs
//   slave : the counter itself
interface lfi_redundant_counter_if;
    logic [7:0] compare_sel;
    logic       clear_fault;
    logic       inject_a;
    logic [3:0] digit;
    logic       digit_tick;
    logic       fault;
    logic [7:0] fault_count;

    modport master (
        output compare_sel,
        output clear_fault,
        output inject_a,
        input  digit,
        input  digit_tick,
        input  fault,
        input  fault_count
    );

    modport slave (
        input  compare_sel,
        input  clear_fault,
        input  inject_a,
        output digit,
        output digit_tick,
        output fault,
        output fault_count
    );
endinterface

// File: rtl/lfi_redundant_counter.sv
// Dual-rail prescaler/digit counter feeding a seven-segment decoder.
// Copy B is stored bit-inverted; any A/B disagreement latches a fault.
// Ports:
//   clk        : system clock
//   reset      : asynchronous, active-high
//   bus.slave  : compare_sel, clear_fault, inject_a in;
//                digit, digit_tick, fault, fault_count out
module lfi_redundant_counter #(
    parameter logic [23:0] MAX_COUNT = 24'd10_000_000
) (
    input  logic                    clk,
    input  logic                    reset,
    lfi_redundant_counter_if.slave  bus
);

    typedef enum logic {
        S_RUN   = 1'b0,
        S_FAULT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [23:0] pre_a_q, pre_a_d;
    logic [3:0]  dig_a_q, dig_a_d;
    logic [23:0] pre_b_q, pre_b_d;
    logic [3:0]  dig_b_q, dig_b_d;
    logic [3:0]  digit_q, digit_d;
    logic        tick_q, tick_d;
    logic        fault_q, fault_d;
    logic [7:0]  fcnt_q, fcnt_d;

    logic [23:0] term;
    logic        mismatch;
    logic        wrap_a, wrap_b;
    logic [23:0] pre_b_log, dig_b_pad;
    logic [3:0]  dig_b_log;
    logic [23:0] inj_mask;

    function automatic logic [23:0] pre_next(
        input logic [23:0] pre,
        input logic [23:0] t
    );
        return (pre >= t) ? 24'd0 : pre + 24'd1;
    endfunction

    function automatic logic [3:0] dig_next(
        input logic [3:0] dig,
        input logic       wrap
    );
        if (!wrap) begin
            return dig;
        end
        // Anything at or above 9 folds back to 0 so a corrupted
        // digit can never walk into the blanking code.
        return (dig >= 4'd9) ? 4'd0 : dig + 4'd1;
    endfunction

    // Shared terminal count; 0 selects the 1 s default.
    always_comb begin
        term = (bus.compare_sel == 8'd0)
             ? MAX_COUNT
             : {6'b0, bus.compare_sel, 10'b0};
    end

    // Copy B evaluated on its logical (de-inverted) value.
    always_comb begin
        pre_b_log = ~pre_b_q;
        dig_b_log = ~dig_b_q;
        dig_b_pad = {20'd0, dig_b_log};
        wrap_a    = (pre_a_q >= term);
        wrap_b    = (pre_b_log >= term);
        inj_mask  = {23'd0, bus.inject_a};
        mismatch  = (pre_a_q != pre_b_log)
                  | (dig_a_q != dig_b_pad[3:0]);
    end

    always_comb begin
        state_d = state_q;
        pre_a_d = pre_a_q;
        dig_a_d = dig_a_q;
        pre_b_d = pre_b_q;
        dig_b_d = dig_b_q;
        digit_d = digit_q;
        tick_d  = 1'b0;
        fault_d = fault_q;
        fcnt_d  = fcnt_q;

        unique case (state_q)
            S_RUN: begin
                if (mismatch) begin
                    // Freeze both copies; the debug flip still
                    // lands on A, and is wiped by the clear reload.
                    state_d = S_FAULT;
                    fault_d = 1'b1;
                    digit_d = 4'hF;
                    pre_a_d = pre_a_q ^ inj_mask;
                    fcnt_d  = (fcnt_q == 8'hFF)
                            ? fcnt_q : fcnt_q + 8'd1;
                end else begin
                    pre_a_d = pre_next(pre_a_q, term) ^ inj_mask;
                    dig_a_d = dig_next(dig_a_q, wrap_a);
                    pre_b_d = ~pre_next(pre_b_log, term);
                    dig_b_d = ~dig_next(dig_b_log, wrap_b);
                    digit_d = dig_next(dig_a_q, wrap_a);
                    tick_d  = wrap_a;
                end
            end
            S_FAULT: begin
                digit_d = 4'hF;
                pre_a_d = pre_a_q ^ inj_mask;
                if (bus.clear_fault) begin
                    state_d = S_RUN;
                    fault_d = 1'b0;
                    digit_d = 4'd0;
                    pre_a_d = 24'd0;
                    dig_a_d = 4'd0;
                    pre_b_d = 24'hFF_FFFF;
                    dig_b_d = 4'hF;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_RUN;
            pre_a_q <= 24'd0;
            dig_a_q <= 4'd0;
            pre_b_q <= 24'hFF_FFFF;
            dig_b_q <= 4'hF;
            digit_q <= 4'd0;
            tick_q  <= 1'b0;
            fault_q <= 1'b0;
            fcnt_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            pre_a_q <= pre_a_d;
            dig_a_q <= dig_a_d;
            pre_b_q <= pre_b_d;
            dig_b_q <= dig_b_d;
            digit_q <= digit_d;
            tick_q  <= tick_d;
            fault_q <= fault_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign bus.digit       = digit_q;
    assign bus.digit_tick  = tick_q;
    assign bus.fault       = fault_q;
    assign bus.fault_count = fcnt_q;

endmodule

// File: tb/tb_lfi_redundant_counter.sv
// Self-checking bench for lfi_redundant_counter: vector table,
// directed corner sequences and randomized run against a model.
module tb_lfi_redundant_counter;

    localparam logic [23:0] MAXC = 24'd3000;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    lfi_redundant_counter_if bus ();

    lfi_redundant_counter #(.MAX_COUNT(MAXC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: cycles since last wrap, logical digit,
    // a pending-upset flag and the fault bookkeeping.
    int m_pre, m_dig, m_fault, m_cnt, m_pend, m_tick;

    function automatic int term_of(input int sel);
        return (sel == 0) ? int'(MAXC) : sel * 1024;
    endfunction

    task automatic model_reset;
        m_pre = 0; m_dig = 0; m_fault = 0;
        m_cnt = 0; m_pend = 0; m_tick = 0;
    endtask

    task automatic model_edge(input int sel, input bit clr,
                              input bit inj);
        m_tick = 0;
        if (m_fault == 0) begin
            if (m_pend != 0) begin
                m_fault = 1;
                m_pend  = 0;
                if (m_cnt < 255) m_cnt++;
            end else begin
                if (m_pre >= term_of(sel)) begin
                    m_pre  = 0;
                    m_dig  = (m_dig + 1) % 10;
                    m_tick = 1;
                end else begin
                    m_pre++;
                end
                if (inj) m_pend = 1;
            end
        end else if (clr) begin
            m_fault = 0;
            m_pre   = 0;
            m_dig   = 0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step;
        model_edge(int'(bus.compare_sel), bus.clear_fault,
                   bus.inject_a);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        bus.clear_fault = 1'b0;
        bus.inject_a = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic wait_tick(input int maxc, output int n,
                             output bit ok);
        ok = 1'b0;
        n = 0;
        while (n < maxc) begin
            step();
            n++;
            if (bus.digit_tick) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic inj_clear;
        bus.inject_a = 1'b1; step(); bus.inject_a = 1'b0;
        step();
        bus.clear_fault = 1'b1; step(); bus.clear_fault = 1'b0;
    endtask

    typedef struct {
        logic [7:0] sel;
        logic       clr;
        logic       inj;
        logic [3:0] dig;
        logic       tick;
        logic       flt;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int  n;
        int  last;
        int  ntick;
        int  bad;
        bit  ok;

        tbl[0]  = '{8'd1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0};
        tbl[1]  = '{8'd1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 8'd0};
        tbl[2]  = '{8'd1, 1'b0, 1'b0, 4'hF, 1'b0, 1'b1, 8'd1};
        tbl[3]  = '{8'd1, 1'b0, 1'b1, 4'hF, 1'b0, 1'b1, 8'd1};
        tbl[4]  = '{8'd1, 1'b0, 1'b0, 4'hF, 1'b0, 1'b1, 8'd1};
        tbl[5]  = '{8'd1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 8'd1};
        tbl[6]  = '{8'd1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 8'd1};
        tbl[7]  = '{8'd1, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 8'd1};
        tbl[8]  = '{8'd1, 1'b0, 1'b0, 4'hF, 1'b0, 1'b1, 8'd2};
        tbl[9]  = '{8'd1, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 8'd2};
        tbl[10] = '{8'd1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 8'd2};
        tbl[11] = '{8'd1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 8'd2};

        bus.compare_sel = 8'd1;
        bus.clear_fault = 1'b0;
        bus.inject_a = 1'b0;
        reset = 1'b1;
        do_reset();

        chk("rst_digit", bus.digit, 4'd0);
        chk("rst_tick", bus.digit_tick, 1'b0);
        chk("rst_fault", bus.fault, 1'b0);
        chk("rst_count", bus.fault_count, 8'd0);

        foreach (tbl[i]) begin
            bus.compare_sel = tbl[i].sel;
            bus.clear_fault = tbl[i].clr;
            bus.inject_a = tbl[i].inj;
            step();
            chk($sformatf("vec%0d_digit", i), bus.digit, tbl[i].dig);
            chk($sformatf("vec%0d_tick", i), bus.digit_tick, tbl[i].tick);
            chk($sformatf("vec%0d_fault", i), bus.fault, tbl[i].flt);
            chk($sformatf("vec%0d_count", i), bus.fault_count, tbl[i].cnt);
        end
        bus.clear_fault = 1'b0;
        bus.inject_a = 1'b0;

        // Tick period and digit sequence with term = 1024.
        do_reset();
        bus.compare_sel = 8'd1;
        last = 0;
        ntick = 0;
        bad = 0;
        for (int c = 1; c <= 10300; c++) begin
            step();
            if (bus.fault) bad++;
            if (bus.digit_tick) begin
                ntick++;
                chk("tick_period", c - last, 1025);
                chk("tick_digit", bus.digit, (ntick % 10));
                last = c;
            end
        end
        chk("tick_count", ntick, 10);
        chk("run_no_fault", bad, 0);

        // Switching to the default terminal count mid-count.
        do_reset();
        bus.compare_sel = 8'd1;
        wait_tick(1100, n, ok);
        chk("first_tick_seen", ok, 1'b1);
        chk("first_tick_n", n, 1025);
        repeat (500) step();
        bus.compare_sel = 8'd0;
        wait_tick(4000, n, ok);
        chk("sel0_tick_seen", ok, 1'b1);
        chk("sel0_period", 500 + n, int'(MAXC) + 1);
        bus.compare_sel = 8'd2;
        repeat (1500) step();
        chk("pre_lower_tick", bus.digit_tick, 1'b0);
        bus.compare_sel = 8'd1;
        step();
        chk("lower_sel_tick", bus.digit_tick, 1'b1);

        // Upset at digit 3, freeze, second upset, recovery.
        do_reset();
        bus.compare_sel = 8'd1;
        for (int k = 0; k < 3; k++) begin
            wait_tick(1100, n, ok);
            chk("reach3_tick", ok, 1'b1);
        end
        chk("at_digit3", bus.digit, 4'd3);
        repeat (10) step();
        bus.inject_a = 1'b1;
        step();
        bus.inject_a = 1'b0;
        chk("inj_edge_fault", bus.fault, 1'b0);
        step();
        chk("inj_fault", bus.fault, 1'b1);
        chk("inj_count", bus.fault_count, 8'd1);
        chk("inj_digit", bus.digit, 4'hF);
        bad = 0;
        repeat (2000) begin
            step();
            if (bus.digit != 4'hF || bus.digit_tick || !bus.fault)
                bad++;
        end
        chk("frozen", bad, 0);
        bus.inject_a = 1'b1;
        step();
        bus.inject_a = 1'b0;
        repeat (3) step();
        chk("second_inj_count", bus.fault_count, 8'd1);
        bus.clear_fault = 1'b1;
        step();
        bus.clear_fault = 1'b0;
        chk("clr_fault", bus.fault, 1'b0);
        chk("clr_digit", bus.digit, 4'd0);
        chk("clr_count", bus.fault_count, 8'd1);
        wait_tick(1100, n, ok);
        chk("clr_tick_seen", ok, 1'b1);
        chk("clr_tick_n", n, 1025);

        // Saturation of the event counter.
        do_reset();
        bus.compare_sel = 8'd1;
        for (int r = 0; r < 260; r++) begin
            inj_clear();
            if (r == 100) chk("sat_mid", bus.fault_count, 8'd101);
        end
        chk("sat_count", bus.fault_count, 8'd255);
        chk("sat_fault", bus.fault, 1'b0);

        // Asynchronous reset while faulted with count 7.
        do_reset();
        bus.compare_sel = 8'd1;
        repeat (6) inj_clear();
        bus.inject_a = 1'b1;
        step();
        bus.inject_a = 1'b0;
        step();
        chk("pre_arst_fault", bus.fault, 1'b1);
        chk("pre_arst_count", bus.fault_count, 8'd7);
        #2 reset = 1'b1;
        #1;
        chk("arst_digit", bus.digit, 4'd0);
        chk("arst_tick", bus.digit_tick, 1'b0);
        chk("arst_fault", bus.fault, 1'b0);
        chk("arst_count", bus.fault_count, 8'd0);
        #2 reset = 1'b0;

        // Randomized run against the model.
        do_reset();
        bus.compare_sel = 8'd1;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(199) == 0)
                bus.compare_sel = 8'($urandom_range(3));
            bus.inject_a = ($urandom_range(299) == 0);
            bus.clear_fault = ($urandom_range(49) == 0);
            step();
            chk("rnd_digit", bus.digit,
                (m_fault != 0) ? 15 : m_dig);
            chk("rnd_tick", bus.digit_tick, m_tick);
            chk("rnd_fault", bus.fault, m_fault);
            chk("rnd_count", bus.fault_count, m_cnt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lfi_redundant_counter.md
# lfi_redundant_counter

Dual-rail seconds/digit counter with fault detection. It sits directly upstream of the seven-segment decoder and supplies the 0–9 digit it displays. Two independent copies of the prescaler and digit state run in lockstep; copy B is stored bit-inverted. Any disagreement between the copies, for example from a laser-induced upset, freezes the display and latches a fault, and a saturating counter records the number of fault events.

## Interface

Parameters:
- MAX_COUNT, 24'd10_000_000, prescaler terminal count used when compare_sel == 0 (1 s at 10 MHz)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset; one clock domain only
- compare_sel  in  8  0 selects MAX_COUNT; otherwise the terminal count is {6'b0, compare_sel, 10'b0}
- clear_fault  in  1  level; acknowledges a latched fault and restarts counting
- inject_a  in  1  debug; XORs bit 0 of copy A's prescaler on that edge
- digit  out  4  displayed digit, 0–9; 4'hF while faulted (decoder blanks)
- digit_tick  out  1  one-cycle pulse on the edge where digit advances
- fault  out  1  sticky fault flag
- fault_count  out  8  number of fault events, saturating at 255

## Operation

- State per copy: 24-bit prescaler and 4-bit digit. Copy B registers hold the bitwise inverse of the logical value.
- Terminal count: term = (compare_sel == 0) ? MAX_COUNT : {6'b0, compare_sel, 10'b0}. It is combinational from compare_sel and shared by both copies.
- Counting step, applied to each copy on its logical value:
  - If pre >= term: pre <= 0, and the digit advances (9 wraps to 0).
  - Otherwise: pre <= pre + 1. Width is 24 bits and is never reached because of the >= test.
  - The >= comparison makes lowering compare_sel mid-count tick on the next edge.
- mismatch = (A.pre != ~B.pre) | (A.digit != ~B.digit). It is evaluated combinationally on the register outputs.
- FSM, two states:
  - RUN: both copies count.
    - If mismatch: go to FAULT. Set fault <= 1. fault_count increments, saturating at 255. Counters hold their values.
  - FAULT: counters frozen. digit output forced to 4'hF. digit_tick = 0. Further mismatch causes no increment.
    - If clear_fault: go to RUN. Both copies load logical 0 (B registers all-ones). fault <= 0. fault_count is retained.
- clear_fault in RUN: no effect.
- inject_a in FAULT: flips copy A as usual. No new event is counted; the flip is overwritten by the clear_fault reload.
- inject_a and clear_fault on the same edge in FAULT: clear wins; A reloads to 0.
- Reset, asynchronous: state RUN. Both copies hold logical 0. digit = 0, digit_tick = 0, fault = 0, fault_count = 0.
- Reset asserted mid-operation, in any state: the reset values above appear immediately, independent of clk.

## Timing

- digit and digit_tick are registered from copy A. The edge where pre >= term is sampled produces digit+1 and digit_tick = 1 in the following cycle.
- Tick period: term + 1 cycles. With compare_sel = 1, the period is 1025 cycles.
- Fault latency: inject_a is sampled at edge N and the A/B mismatch exists after edge N. At edge N+1, fault = 1, fault_count increments, and digit reads 4'hF.
- Recovery: clear_fault is sampled at edge M. After M, the block is in RUN with digit = 0 and pre = 0. The first digit_tick arrives term + 1 cycles later.
- No input handshakes. All outputs are registered; fault and fault_count change only on clk edges or reset.

## Test plan

- Reset, then compare_sel = 1 for 10,300 cycles:
  - digit_tick pulses every 1025 cycles.
  - digit steps through 0..9 and back to 0.
  - fault stays 0.
- compare_sel = 1; at pre = 500 switch to compare_sel = 0 and wait:
  - No tick until the pre >= MAX_COUNT edge.
  - That tick is exactly MAX_COUNT + 1 cycles after the last wrap.
- Pulse inject_a once at digit = 3:
  - One edge later: fault = 1, fault_count = 1, digit = 4'hF.
  - Counters frozen for 2000 cycles.
  - A second inject_a leaves fault_count at 1.
- From FAULT, assert clear_fault for one cycle:
  - Next cycle: fault = 0, digit = 0, fault_count = 1.
  - First digit_tick follows term + 1 cycles later.
- Repeat the inject/clear sequence 260 times: fault_count saturates at 255 and does not wrap.
- Assert reset asynchronously between clock edges while in FAULT with fault_count = 7: all outputs reach their reset values without a clock edge.
